// File: rtl/dac_frame_rx_pkg.sv
// Shared definitions for the DAC frame receiver and the ADC transmit path:
// frame-state encoding, frame start byte and default sizing.
package dac_frame_rx_pkg;

  // Byte-wide state encoding, identical to the ADC path so captures compare directly.
  typedef enum logic [7:0] {
    HUNT   = 8'h00,
    LEN_LB = 8'h01,
    LEN_HB = 8'h02,
    LOAD   = 8'h03,
    PLAY   = 8'h04
  } state_t;

  localparam logic [7:0] FLAG_DEFAULT  = 8'h5a;
  localparam int         DEPTH_DEFAULT = 1024;
  localparam int         DIV_DEFAULT   = 8;

endpackage

// File: rtl/dac_frame_rx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is always
// visible on dout while not empty; pop advances to the next entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush empties the FIFO without touching the storage.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; the pointers define which
    // entries are valid, and a reset would prevent mapping onto block RAM.
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dac_frame_rx.sv
// Receives 0x5A-flagged, length-prefixed frames from the SPI byte interface,
// buffers the payload and replays it to an 8-bit DAC, one sample every DIV clocks.
module dac_frame_rx
  import dac_frame_rx_pkg::*;
#(
  parameter int         DEPTH = DEPTH_DEFAULT,
  parameter int         DIV   = DIV_DEFAULT,
  parameter logic [7:0] FLAG  = FLAG_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rxd_data,
  input  logic       rxd_flag,
  output logic [7:0] dac_data,
  output logic       dac_clk,
  output logic       busy,
  output logic       frame_done,
  output logic       overflow
);

  localparam int               DIV_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);

  state_t           state;
  logic [15:0]      len;
  logic [15:0]      rx_cnt;
  logic [DIV_W-1:0] div_cnt;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;

  // Bytes beyond the buffer capacity are dropped; playback pops at the start of each period.
  assign fifo_push = (state == LOAD) && rxd_flag && !fifo_full;
  assign fifo_pop  = (state == PLAY) && (div_cnt == '0) && !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .flush (reset),
    .push  (fifo_push),
    .din   (rxd_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame FSM with length/count registers, sample divider and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      len        <= '0;
      rx_cnt     <= '0;
      div_cnt    <= '0;
      dac_data   <= '0;
      dac_clk    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        HUNT: begin
          if (rxd_flag && (rxd_data == FLAG)) begin
            state    <= LEN_LB;
            busy     <= 1'b1;
            overflow <= 1'b0;
            rx_cnt   <= '0;
          end
        end

        LEN_LB: begin
          if (rxd_flag) begin
            len[7:0] <= rxd_data;
            state    <= LEN_HB;
          end
        end

        LEN_HB: begin
          if (rxd_flag) begin
            len[15:8] <= rxd_data;
            if ({rxd_data, len[7:0]} == 16'd0) begin
              // Empty frame: nothing to play, close it out immediately.
              state      <= HUNT;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end

        LOAD: begin
          if (rxd_flag) begin
            rx_cnt <= rx_cnt + 16'd1;
            if (fifo_full)
              overflow <= 1'b1;
            if ((rx_cnt + 16'd1) == len) begin
              state   <= PLAY;
              div_cnt <= '0;
            end
          end
        end

        PLAY: begin
          div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
          dac_clk <= (div_cnt >= DIV_HALF);
          if (div_cnt == '0) begin
            if (!fifo_empty) begin
              dac_data <= fifo_dout;
            end else begin
              // Previous sample has had its full period; the frame is finished.
              state      <= HUNT;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              dac_clk    <= 1'b0;
              div_cnt    <= '0;
            end
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule
